// File: rtl/answer_judge.sv
// answer_judge: answer-side judge for the quiz control block.
// Latches the expected factor pair per question, collects two committed
// player factors, compares them order-insensitively, and drives the
// judgement, wrong-flash, HP and OK signals back to the control block.
//
// Ports:
//   CLK, RST         clock (rising edge), async active-high reset
//   NEW_GAME         pulse: reload HP, return to IDLE
//   QUE_LOAD         pulse: latch EXP_A/EXP_B and start a question
//   EXP_A, EXP_B     expected factor pair
//   SEL_OUT          selected factor value, committed by DEC_OUT
//   DEC_OUT          pulse: commit SEL_OUT as the next factor
//   CLR_OUT          pulse: discard the first entered factor
//   JUDG             00 none, 01 correct, 10 wrong, 11 game over
//   WRONG            11 during the wrong-hold window, else 00
//   HP               remaining hit points
//   OK               one-cycle pulse on a correct answer
//   BUSY             high while a question is in progress
module answer_judge #(
  parameter int unsigned HP_INIT    = 3,
  parameter int unsigned WRONG_HOLD = 4,
  parameter int unsigned SEL_W      = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             NEW_GAME,
  input  logic             QUE_LOAD,
  input  logic [SEL_W-1:0] EXP_A,
  input  logic [SEL_W-1:0] EXP_B,
  input  logic [SEL_W-1:0] SEL_OUT,
  input  logic             DEC_OUT,
  input  logic             CLR_OUT,
  output logic [1:0]       JUDG,
  output logic [1:0]       WRONG,
  output logic [1:0]       HP,
  output logic             OK,
  output logic             BUSY
);

  localparam int unsigned HP_W  = 2;
  localparam int unsigned CNT_W = (WRONG_HOLD > 1) ? $clog2(WRONG_HOLD) : 1;

  localparam logic [1:0] JUDG_NONE  = 2'b00;
  localparam logic [1:0] JUDG_RIGHT = 2'b01;
  localparam logic [1:0] JUDG_MISS  = 2'b10;
  localparam logic [1:0] JUDG_OVER  = 2'b11;
  localparam logic [1:0] WRONG_ON   = 2'b11;
  localparam logic [1:0] WRONG_OFF  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND,
    S_CHECK,
    S_RIGHT,
    S_MISS,
    S_OVER
  } state_t;

  state_t           state, state_d;
  logic [SEL_W-1:0] f1, f1_d, f2, f2_d;
  logic [SEL_W-1:0] exp_a, exp_a_d, exp_b, exp_b_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       judg_d, wrong_d;
  logic [HP_W-1:0]  hp_d;
  logic             ok_d, busy_d;
  logic             match;

  // Order-insensitive pair comparison
  assign match = ((f1 == exp_a) && (f2 == exp_b)) ||
                 ((f1 == exp_b) && (f2 == exp_a));

  // State register and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      f1    <= '0;
      f2    <= '0;
      exp_a <= '0;
      exp_b <= '0;
      cnt   <= '0;
      JUDG  <= JUDG_NONE;
      WRONG <= WRONG_OFF;
      HP    <= HP_W'(HP_INIT);
      OK    <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_d;
      f1    <= f1_d;
      f2    <= f2_d;
      exp_a <= exp_a_d;
      exp_b <= exp_b_d;
      cnt   <= cnt_d;
      JUDG  <= judg_d;
      WRONG <= wrong_d;
      HP    <= hp_d;
      OK    <= ok_d;
      BUSY  <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    f1_d    = f1;
    f2_d    = f2;
    exp_a_d = exp_a;
    exp_b_d = exp_b;
    cnt_d   = cnt;
    judg_d  = JUDG;
    wrong_d = WRONG;
    hp_d    = HP;
    ok_d    = 1'b0;

    if (NEW_GAME) begin
      hp_d    = HP_W'(HP_INIT);
      judg_d  = JUDG_NONE;
      wrong_d = WRONG_OFF;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else if (QUE_LOAD && (state != S_OVER)) begin
      exp_a_d = EXP_A;
      exp_b_d = EXP_B;
      f1_d    = '0;
      f2_d    = '0;
      judg_d  = JUDG_NONE;
      wrong_d = WRONG_OFF;
      cnt_d   = '0;
      state_d = S_FIRST;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_FIRST: begin
          if (DEC_OUT) begin
            f1_d    = SEL_OUT;
            state_d = S_SECOND;
          end
        end
        S_SECOND: begin
          if (CLR_OUT) begin
            f1_d    = '0;
            state_d = S_FIRST;
          end else if (DEC_OUT) begin
            f2_d    = SEL_OUT;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (match) begin
            state_d = S_RIGHT;
          end else begin
            hp_d    = (HP == '0) ? '0 : HP - HP_W'(1);
            cnt_d   = CNT_W'(WRONG_HOLD - 1);
            state_d = S_MISS;
          end
        end
        S_RIGHT: begin
          judg_d  = JUDG_RIGHT;
          ok_d    = 1'b1;
          state_d = S_IDLE;
        end
        S_MISS: begin
          // First MISS cycle raises the flash; the counter then times the hold
          if (WRONG != WRONG_ON) begin
            wrong_d = WRONG_ON;
            judg_d  = JUDG_MISS;
          end else if (cnt == '0) begin
            wrong_d = WRONG_OFF;
            if (HP == '0) begin
              judg_d  = JUDG_OVER;
              state_d = S_OVER;
            end else begin
              judg_d  = JUDG_NONE;
              f1_d    = '0;
              f2_d    = '0;
              state_d = S_FIRST;
            end
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        S_OVER: begin
          judg_d = JUDG_OVER;
          hp_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_FIRST) || (state_d == S_SECOND) ||
             (state_d == S_CHECK) || (state_d == S_MISS);
  end

endmodule

// File: doc/answer_judge.md
Name: answer_judge

Overview:
- Answer-side counterpart of the quiz control block: consumes its committed selections (SEL_OUT/DEC_OUT/CLR_OUT) and produces the judgement, wrong-flash, HP and OK signals that the control block takes as JUDG_IN/WRONG_IN/HP_IN/OK_IN.
- Latches the expected factor pair for each question and collects two player factors.
- Compares the player factors order-insensitively against the expected pair, manages player HP and signals game over.

Parameters:
HP_INIT, 3, HP loaded at reset and on NEW_GAME (1..3, fits 2 bits)
WRONG_HOLD, 4, cycles WRONG stays 2'b11 after a miss (>=1)
SEL_W, 3, width of factor/selection values

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
NEW_GAME  in  1  1-cycle pulse: reload HP, go IDLE
QUE_LOAD  in  1  1-cycle pulse: latch EXP_A/EXP_B, start question
EXP_A  in  SEL_W  expected factor A
EXP_B  in  SEL_W  expected factor B
SEL_OUT  in  SEL_W  selected factor value from control
DEC_OUT  in  1  1-cycle commit pulse for SEL_OUT
CLR_OUT  in  1  1-cycle pulse: discard first entered factor
JUDG  out  2  00 none, 01 correct, 10 wrong, 11 game over
WRONG  out  2  11 during wrong-hold window, else 00
HP  out  2  remaining HP
OK  out  1  1-cycle pulse on correct answer
BUSY  out  1  high in FIRST/SECOND/CHECK/MISS

Behaviour:
- Reset values (async): state=IDLE; JUDG=00; WRONG=00; HP=HP_INIT; OK=0; BUSY=0; f1, f2, exp_a, exp_b, hold counter all 0. All outputs are registered.
- Input priority, same cycle: NEW_GAME > QUE_LOAD > CLR_OUT > DEC_OUT.
- NEW_GAME, any state: HP=HP_INIT, JUDG=00, WRONG=00, counter=0, state=IDLE.
- QUE_LOAD, any state except OVER: latch EXP_A/EXP_B; clear f1/f2, JUDG, WRONG and counter; state=FIRST. QUE_LOAD in OVER is ignored.
- IDLE: wait. JUDG holds its last result.
- FIRST: DEC_OUT latches f1=SEL_OUT and goes to SECOND. CLR_OUT has no effect.
- SECOND:
  - CLR_OUT clears f1 and returns to FIRST. It wins over a simultaneous DEC_OUT.
  - DEC_OUT latches f2=SEL_OUT and goes to CHECK.
- CHECK (exactly 1 cycle): match = ({f1,f2}=={exp_a,exp_b}) or ({f1,f2}=={exp_b,exp_a}).
  - match: state=RIGHT.
  - else: state=MISS; HP decrements, saturating at 0.
- Latency: with the second DEC_OUT sampled at edge n, CHECK is entered at n+1 and result outputs update at edge n+2.
- RIGHT:
  - JUDG=01 and OK=1 for exactly one cycle.
  - Next state IDLE; JUDG stays 01 until the next QUE_LOAD or NEW_GAME.
- MISS:
  - JUDG=10 and WRONG=11 for exactly WRONG_HOLD cycles; the counter counts WRONG_HOLD-1 down to 0.
  - Hold end, HP>0: WRONG=00, JUDG=00, clear f1/f2, state=FIRST (retry same question).
  - Hold end, HP==0: WRONG=00, JUDG=11, state=OVER.
  - DEC_OUT/CLR_OUT during MISS are ignored.
- OVER: JUDG=11 and HP=0 held; only NEW_GAME or RST exits.
- DEC_OUT/CLR_OUT in IDLE, CHECK, RIGHT and OVER are ignored.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- QUE_LOAD during a MISS hold aborts the hold. The HP decrement already taken stands.

Test Plan:
- Reset, NEW_GAME; QUE_LOAD EXP_A=2, EXP_B=5; DEC SEL=5 then DEC SEL=2 -> OK one cycle at 2 clocks after the second DEC, JUDG=01, HP=3, WRONG=00.
- Same question; DEC 3, DEC 5 -> WRONG=11 for exactly 4 cycles, JUDG=10, HP=2, then state FIRST, JUDG=00.
- Three consecutive wrong pairs from HP=3 -> HP 2,1,0; after the third hold JUDG=11 stays; QUE_LOAD ignored; NEW_GAME -> HP=3, JUDG=00.
- DEC 4; CLR_OUT; DEC 2; DEC 5 (expected 2,5) -> correct. CLR_OUT and DEC_OUT in the same cycle in SECOND -> f1 cleared, no CHECK.
- Assert RST for 1 ns mid-MISS, between clock edges -> WRONG=00, JUDG=00, HP=3 immediately; DEC pulses afterwards ignored until QUE_LOAD.
- QUE_LOAD during a MISS hold -> WRONG=00 on the next cycle, state FIRST, HP keeps the decremented value.
